core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control sequencer for the RV32 core. It walks each instruction through fetch, decode, execute, memory and writeback. It handshakes with instruction and data memory and gates the decoder's static enables (register write, memory write, branch) into single-cycle strobes. It sits between the instruction register / decoder and the PC, register file and data-memory ports.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; passed to the PC register, not used internally.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  inst[6:0] from the instruction register; stable from DECODE onward.
- `w_en`  in  1  decoder register-write enable.
- `mw_en`  in  1  decoder memory-write enable.
- `jump_en`  in  1  decoder branch flag.
- `branch_taken`  in  1  branch comparator result; valid in EXEC.
- `imem_ready`  in  1  instruction memory data valid.
- `dmem_ready`  in  1  data memory access complete.
- `halt_req`  in  1  external halt request.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  instruction register load strobe.
- `dmem_req`  out  1  data memory access request.
- `dmem_we`  out  1  data memory write (qualifies `dmem_req`).
- `rf_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC update strobe.
- `pc_sel`  out  1  0: PC+4, 1: PC+jump_offset.
- `illegal`  out  1  one-cycle pulse on an unrecognised opcode.
- `halted`  out  1  sequencer is in HALT.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 return to FETCH on the next cycle and drive all strobes 0.
- Reset:
  - state = FETCH.
  - All strobes 0 except `imem_req`, which equals `!halt_req`.
  - `halted` = 0; perf counters = 0.
- FETCH:
  - If `halt_req`=1: go to HALT and do not assert `imem_req`.
  - Otherwise assert `imem_req`. When `imem_ready`=1, pulse `ir_we` and go to DECODE. Stay in FETCH while `imem_ready`=0.
- DECODE: one cycle, no strobes, then EXEC.
- EXEC, branched on `opcode`:
  - B (1100011): pulse `pc_we`, drive `pc_sel`=`jump_en & branch_taken`, go to FETCH.
  - Load (0000011) or store (0100011): go to MEM.
  - R (0110011), I-ALU (0010011) or custom-0 (0001011): go to WB.
  - Any other opcode: pulse `illegal`, pulse `pc_we` with `pc_sel`=0, go to FETCH. The instruction is treated as a NOP.
- MEM:
  - Hold `dmem_req`=1 and `dmem_we`=`mw_en` until `dmem_ready`.
  - On `dmem_ready`: a store pulses `pc_we` (`pc_sel`=0) and goes to FETCH; a load goes to WB.
- WB: pulse `rf_we`=`w_en` and `pc_we` (`pc_sel`=0), then go to FETCH.
- HALT: `halted`=1, no strobes. Leave to FETCH on the first cycle with `halt_req`=0.
- `halt_req` is sampled only in FETCH. A request raised mid-instruction takes effect after the instruction retires.
- Exactly one `pc_we` pulse per retired instruction. `rf_we` and `pc_we` are never asserted outside the states listed above.

## Timing
- State register updates on the rising edge; outputs are combinational from the state plus inputs. No output depends on a combinational loop through `imem_ready`/`dmem_ready`.
- Latency with zero-wait memory:
  - R / I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and illegal: 3 cycles.
- Each memory wait cycle adds exactly one cycle.
- `rst` asserted in any state, including mid-MEM with `dmem_req` high, forces FETCH immediately. It drops `dmem_req` in the same cycle, and no strobe pulses after reset.
- If `halt_req` and `imem_ready` are both 1 in FETCH, halt wins: no fetch and no `ir_we`.

## Configuration
- `CORE_SEQ_PERF_EN` defined: adds `cycle_cnt` (out, 32) and `instret_cnt` (out, 32).
  - `cycle_cnt` increments every cycle except in HALT.
  - `instret_cnt` increments on each `pc_we` pulse, excluding illegal opcodes.
  - Both wrap from 32'hFFFF_FFFF to 0 and reset to 0.
- Not defined: the ports and counters are absent and sequencing is identical.

## Structure
- Shared package `core_pkg`:
  - State encoding constants.
  - Opcode constants: R, I, I_ALU, B, S, D.
  - `pc_sel` encodings.
- Sub-module `core_seq_perf_cnt`: the two counters, instantiated only under `CORE_SEQ_PERF_EN`.

## Test plan
- R-type (0110011), `w_en`=1, `imem_ready` tied 1: states 0,1,2,4. `rf_we` and `pc_we` pulse together on cycle 4, `pc_sel`=0.
- Load (0000011), `dmem_ready` low for 2 cycles in MEM: `dmem_req`=1 for 3 cycles with `dmem_we`=0, then WB. Total 7 cycles, one `rf_we`.
- Branch (1100011), `jump_en`=1, `branch_taken`=1: `pc_we`=1 and `pc_sel`=1 on cycle 3. With `branch_taken`=0, `pc_sel`=0.
- Opcode 1111111: `illegal` pulses once in EXEC, `pc_we`=1, back to FETCH. With the macro on, `instret_cnt` is unchanged.
- `halt_req`=1 raised during EXEC of an R-type: WB completes, then HALT with `imem_req`=0. Dropping `halt_req` resumes FETCH the next cycle.
- `rst` pulsed while in MEM with `dmem_req`=1: `dmem_req` falls the same cycle and state=0. With the macro on, counters read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 multi-cycle control sequencer:
// state encoding, opcode constants, pc_sel encodings and opcode classification.
package core_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } seq_state_e;

   // Major opcodes (inst[6:0]) the sequencer understands.
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0000011;  // load
   localparam logic [6:0] OP_I_ALU = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_S     = 7'b0100011;  // store
   localparam logic [6:0] OP_D     = 7'b0001011;  // custom-0

   // pc_sel encodings.
   localparam logic PC_SEL_SEQ  = 1'b0;  // PC + 4
   localparam logic PC_SEL_JUMP = 1'b1;  // PC + jump_offset

   typedef enum logic [1:0] {
      CLS_BRANCH  = 2'd0,
      CLS_MEM     = 2'd1,
      CLS_ALU     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_e;

   // Map an opcode onto the path it takes out of EXEC.
   function automatic op_class_e classify(input logic [6:0] op);
      op_class_e cls;
      case (op)
         OP_B:                cls = CLS_BRANCH;
         OP_I, OP_S:          cls = CLS_MEM;
         OP_R, OP_I_ALU, OP_D: cls = CLS_ALU;
         default:             cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/core_seq_perf_cnt.sv
// Performance counters for the sequencer: active cycles and retired
// instructions. Both wrap at 32 bits. Only instantiated when
// CORE_SEQ_PERF_EN is defined.
module core_seq_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        cycle_inc,
   input  logic        retire_inc,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   logic [31:0] cycle_r;
   logic [31:0] instret_r;

   // Count non-halted cycles and retired instructions; natural wrap at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_r   <= 32'd0;
         instret_r <= 32'd0;
      end else begin
         if (cycle_inc) begin
            cycle_r <= cycle_r + 32'd1;
         end
         if (retire_inc) begin
            instret_r <= instret_r + 32'd1;
         end
      end
   end

   assign cycle_cnt   = cycle_r;
   assign instret_cnt = instret_r;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32 core (FETCH, DECODE, EXEC,
// MEM, WB, HALT). Decoder enables are gated into single-cycle strobes.
// Strobes are decoded from the state plus live inputs so that the memory
// handshakes complete in the cycle ready is seen; reset drops them at once.
// Optional feature macro: CORE_SEQ_PERF_EN adds cycle_cnt / instret_cnt.
module core_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        w_en,
   input  logic        mw_en,
   input  logic        jump_en,
   input  logic        branch_taken,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        halt_req,
   output logic        imem_req,
   output logic        ir_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        illegal,
   output logic        halted,
   output logic [2:0]  state
`ifdef CORE_SEQ_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   // RESET_PC belongs to the PC register; only its alignment is checked here.
   if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
      $error("core_sequencer: RESET_PC must be word aligned");
   end

   seq_state_e state_r;
   op_class_e  op_class;
   logic       is_store;

   assign op_class = classify(opcode);
   assign is_store = (opcode == OP_S);

   // State register: advance through the instruction phases; unused codes recover to FETCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_FETCH;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (halt_req) begin
                  state_r <= ST_HALT;
               end else if (imem_ready) begin
                  state_r <= ST_DECODE;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_DECODE: state_r <= ST_EXEC;
            ST_EXEC: begin
               case (op_class)
                  CLS_MEM: state_r <= ST_MEM;
                  CLS_ALU: state_r <= ST_WB;
                  default: state_r <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (dmem_ready) begin
                  state_r <= is_store ? ST_FETCH : ST_WB;
               end else begin
                  state_r <= ST_MEM;
               end
            end
            ST_WB: state_r <= ST_FETCH;
            ST_HALT: begin
               if (halt_req) begin
                  state_r <= ST_HALT;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            default: state_r <= ST_FETCH;
         endcase
      end
   end

   // Strobe decode from state and inputs; everything but imem_req is forced low under reset.
   always_comb begin
      imem_req = (state_r == ST_FETCH) && !halt_req;
      halted   = (state_r == ST_HALT);
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_SEL_SEQ;
      illegal  = 1'b0;
      if (rst) begin
         ir_we = 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: ir_we = imem_ready && !halt_req;
            ST_EXEC: begin
               case (op_class)
                  CLS_BRANCH: begin
                     pc_we  = 1'b1;
                     pc_sel = (jump_en && branch_taken) ? PC_SEL_JUMP : PC_SEL_SEQ;
                  end
                  CLS_ILLEGAL: begin
                     pc_we   = 1'b1;
                     illegal = 1'b1;
                  end
                  default: pc_we = 1'b0;
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = mw_en;
               pc_we    = dmem_ready && is_store;
            end
            ST_WB: begin
               rf_we = w_en;
               pc_we = 1'b1;
            end
            default: pc_we = 1'b0;
         endcase
      end
   end

   assign state = state_r;

`ifdef CORE_SEQ_PERF_EN
   logic cycle_inc;
   logic retire_inc;

   assign cycle_inc  = (state_r != ST_HALT);
   assign retire_inc = pc_we && !illegal;

   core_seq_perf_cnt u_perf_cnt (
      .clk         (clk),
      .rst         (rst),
      .cycle_inc   (cycle_inc),
      .retire_inc  (retire_inc),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. Each instruction is expanded by a
// transaction-level model into its expected per-cycle trace (state and
// strobes) from the instruction class and memory wait counts; every cycle is
// compared at the falling edge. Latencies are pinned with literal values.
module tb_core_sequencer;

   localparam logic [6:0] T_R    = 7'b0110011;
   localparam logic [6:0] T_IALU = 7'b0010011;
   localparam logic [6:0] T_CUST = 7'b0001011;
   localparam logic [6:0] T_LD   = 7'b0000011;
   localparam logic [6:0] T_ST   = 7'b0100011;
   localparam logic [6:0] T_BR   = 7'b1100011;
   localparam logic [6:0] T_BAD  = 7'b1111111;

   // Strobe vector: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, illegal, halted}
   localparam logic [8:0] F_IMEM  = 9'b100000000;
   localparam logic [8:0] F_IRWE  = 9'b010000000;
   localparam logic [8:0] F_DREQ  = 9'b001000000;
   localparam logic [8:0] F_DWE   = 9'b000100000;
   localparam logic [8:0] F_RFWE  = 9'b000010000;
   localparam logic [8:0] F_PCWE  = 9'b000001000;
   localparam logic [8:0] F_PCSEL = 9'b000000100;
   localparam logic [8:0] F_ILL   = 9'b000000010;
   localparam logic [8:0] F_HALT  = 9'b000000001;
   localparam logic [8:0] F_NONE  = 9'b000000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        w_en, mw_en, jump_en, branch_taken;
   logic        imem_ready, dmem_ready, halt_req;
   logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, illegal, halted;
   logic [2:0]  state;
`ifdef CORE_SEQ_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int model_cyc = 0;
   int model_ret = 0;
   int lat;

   always #5 clk = ~clk;

   core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .w_en         (w_en),
      .mw_en        (mw_en),
      .jump_en      (jump_en),
      .branch_taken (branch_taken),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .halt_req     (halt_req),
      .imem_req     (imem_req),
      .ir_we        (ir_we),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .rf_we        (rf_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .illegal      (illegal),
      .halted       (halted),
      .state        (state)
`ifdef CORE_SEQ_PERF_EN
      ,
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
`endif
   );

   function automatic logic [31:0] strobes();
      return {23'd0, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, illegal, halted};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One clock cycle: apply inputs, compare against the model trace, advance the counter model.
   task automatic cyc(input string tag, input logic [6:0] op, input logic w, input logic mw,
                      input logic je, input logic bt, input logic imr, input logic dmr,
                      input logic hr, input logic [2:0] es, input logic [8:0] ef);
      opcode = op; w_en = w; mw_en = mw; jump_en = je; branch_taken = bt;
      imem_ready = imr; dmem_ready = dmr; halt_req = hr;
      @(negedge clk);
      chk({tag, " state"}, {29'd0, state}, {29'd0, es});
      chk({tag, " strobes"}, strobes(), {23'd0, ef});
`ifdef CORE_SEQ_PERF_EN
      chk({tag, " cycle_cnt"}, cycle_cnt, model_cyc);
      chk({tag, " instret_cnt"}, instret_cnt, model_ret);
`endif
      if (es != 3'd5) model_cyc++;
      if (ef[3] && !ef[1]) model_ret++;
      @(posedge clk);
      #1;
   endtask

   // Expand one instruction into its expected cycle trace from its class and wait counts.
   task automatic run_instr(input string tag, input logic [6:0] op, input logic w, input logic mw,
                            input logic je, input logic bt, input int iwait, input int dwait,
                            input logic hr_late, output int n);
      logic       is_b, is_ld, is_st, is_alu, is_ill, hr;
      logic [8:0] ef, dwe;
      is_b   = (op == T_BR);
      is_ld  = (op == T_LD);
      is_st  = (op == T_ST);
      is_alu = (op == T_R) || (op == T_IALU) || (op == T_CUST);
      is_ill = !(is_b || is_ld || is_st || is_alu);
      dwe    = mw ? F_DWE : F_NONE;
      n  = 0;
      hr = 1'b0;
      for (int i = 0; i < iwait; i++) begin
         cyc(tag, op, w, mw, je, bt, 1'b0, 1'b1, hr, 3'd0, F_IMEM); n++;
      end
      cyc(tag, op, w, mw, je, bt, 1'b1, 1'b1, hr, 3'd0, F_IMEM | F_IRWE); n++;
      cyc(tag, op, w, mw, je, bt, 1'b1, 1'b1, hr, 3'd1, F_NONE); n++;
      hr = hr_late;
      if (is_b) ef = F_PCWE | ((je && bt) ? F_PCSEL : F_NONE);
      else if (is_ill) ef = F_PCWE | F_ILL;
      else ef = F_NONE;
      cyc(tag, op, w, mw, je, bt, 1'b1, 1'b1, hr, 3'd2, ef); n++;
      if (is_ld || is_st) begin
         for (int i = 0; i < dwait; i++) begin
            cyc(tag, op, w, mw, je, bt, 1'b1, 1'b0, hr, 3'd3, F_DREQ | dwe); n++;
         end
         cyc(tag, op, w, mw, je, bt, 1'b1, 1'b1, hr, 3'd3,
             F_DREQ | dwe | (is_st ? F_PCWE : F_NONE)); n++;
      end
      if (is_ld || is_alu) begin
         cyc(tag, op, w, mw, je, bt, 1'b1, 1'b1, hr, 3'd4, (w ? F_RFWE : F_NONE) | F_PCWE); n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; opcode = T_R; w_en = 1'b0; mw_en = 1'b0; jump_en = 1'b0;
      branch_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; halt_req = 1'b0;
      #2;
      chk("reset state", {29'd0, state}, 32'd0);
      chk("reset strobes", strobes(), {23'd0, F_IMEM});
      halt_req = 1'b1;
      #1;
      chk("reset halt strobes", strobes(), 32'd0);
`ifdef CORE_SEQ_PERF_EN
      chk("reset cycle_cnt", cycle_cnt, 32'd0);
      chk("reset instret_cnt", instret_cnt, 32'd0);
`endif
      halt_req = 1'b0;
      @(posedge clk);
      #1;
      chk("reset held state", {29'd0, state}, 32'd0);
      rst = 1'b0;

      run_instr("r_type", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, lat);
      chk("lat r_type", lat, 32'd4);
`ifdef CORE_SEQ_PERF_EN
      chk("r_type cycle_cnt literal", cycle_cnt, 32'd4);
      chk("r_type instret literal", instret_cnt, 32'd1);
`endif
      run_instr("i_alu_iwait", T_IALU, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, lat);
      chk("lat i_alu_iwait", lat, 32'd5);
      run_instr("custom0_now", T_CUST, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, lat);
      chk("lat custom0", lat, 32'd4);
      run_instr("load_w2", T_LD, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0, lat);
      chk("lat load_w2", lat, 32'd7);
      run_instr("load", T_LD, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, lat);
      chk("lat load", lat, 32'd5);
      run_instr("store", T_ST, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, lat);
      chk("lat store", lat, 32'd4);
      run_instr("store_w1", T_ST, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, lat);
      chk("lat store_w1", lat, 32'd5);
      run_instr("br_taken", T_BR, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, lat);
      chk("lat br_taken", lat, 32'd3);
      run_instr("br_not_taken", T_BR, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, lat);
      run_instr("br_no_jump", T_BR, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, lat);
      run_instr("illegal", T_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, lat);
      chk("lat illegal", lat, 32'd3);

      // Halt raised mid-instruction: R-type retires, then FETCH declines and HALT holds.
      run_instr("r_halt", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, lat);
      chk("lat r_halt", lat, 32'd4);
      cyc("halt_fetch", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, F_NONE);
      cyc("halt_hold", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, F_HALT);
      cyc("halt_hold2", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, F_HALT);
      cyc("halt_release", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, F_HALT);
      run_instr("r_resume", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, lat);
      chk("lat r_resume", lat, 32'd4);

      // Reset mid-MEM: dmem_req must fall in the same cycle.
      cyc("rst_fetch", T_LD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, F_IMEM | F_IRWE);
      cyc("rst_decode", T_LD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, F_NONE);
      cyc("rst_exec", T_LD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, F_NONE);
      dmem_ready = 1'b0;
      #1;
      chk("mem before rst state", {29'd0, state}, 32'd3);
      chk("mem before rst dmem_req", {31'd0, dmem_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mem rst state", {29'd0, state}, 32'd0);
      chk("mem rst dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("mem rst strobes", strobes(), {23'd0, F_IMEM});
`ifdef CORE_SEQ_PERF_EN
      chk("mem rst cycle_cnt", cycle_cnt, 32'd0);
      chk("mem rst instret_cnt", instret_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      chk("mem rst held state", {29'd0, state}, 32'd0);
      model_cyc = 0;
      model_ret = 0;
      rst = 1'b0;
      run_instr("r_after_rst", T_R, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, lat);
      chk("lat r_after_rst", lat, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
